// File: rtl/writeback_queue.sv
// Register-file writeback queue: ALU and load results merge into one FIFO that drains one write per cycle.
// Define WBQ_BYPASS_EN to let an offer accepted into an empty, unheld queue go straight to the output registers.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     AluValid,
    input  logic [3:0]               AluReg,
    input  logic [31:0]              AluData,
    output logic                     AluReady,
    input  logic                     MemValid,
    input  logic [3:0]               MemReg,
    input  logic [31:0]              MemData,
    output logic                     MemReady,
    input  logic                     Hold,
    output logic [3:0]               WriteReg,
    output logic [31:0]              Data,
    output logic                     WriteEnable,
    output logic [15:0]              Pending,
    output logic [$clog2(DEPTH):0]   Count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]       reg_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [3:0]       wreg_q;
    logic [31:0]      wdata_q;
    logic             we_q;

    logic             full, empty, acc_alu, acc_mem, push_cand, push, pop, bypass;
    logic [3:0]       in_reg;
    logic [31:0]      in_data;
    logic [15:0]      pend;

    // Ready is derived from the registered occupancy only, so a full queue
    // refuses offers even in a cycle where it is also draining.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        AluReady  = !full;
        MemReady  = !full && !AluValid;
        acc_alu   = AluValid && AluReady;
        acc_mem   = MemValid && MemReady;
        in_reg    = acc_alu ? AluReg  : MemReg;
        in_data   = acc_alu ? AluData : MemData;
        push_cand = (acc_alu || acc_mem) && (in_reg != 4'd0);
        pop       = !Hold && !empty;
`ifdef WBQ_BYPASS_EN
        bypass    = push_cand && empty && !Hold;
`else
        bypass    = 1'b0;
`endif
        push      = push_cand && !bypass;
        vld_d     = vld_q;
        if (pop)  vld_d[rd_ptr_q] = 1'b0;
        if (push) vld_d[wr_ptr_q] = 1'b1;
        count_d   = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= 4'd0;
                data_q[i] <= 32'd0;
            end
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wreg_q   <= 4'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
        end else begin
            if (push) begin
                reg_q[wr_ptr_q]  <= in_reg;
                data_q[wr_ptr_q] <= in_data;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            vld_q   <= vld_d;
            count_q <= count_d;
            if (pop) begin
                wreg_q  <= reg_q[rd_ptr_q];
                wdata_q <= data_q[rd_ptr_q];
                we_q    <= 1'b1;
            end else if (bypass) begin
                wreg_q  <= in_reg;
                wdata_q <= in_data;
                we_q    <= 1'b1;
            end else begin
                we_q    <= 1'b0;
            end
        end
    end

    always_comb begin
        pend = 16'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) pend[reg_q[i]] = 1'b1;
        end
        if (we_q) pend[wreg_q] = 1'b1;
        pend[0] = 1'b0;
    end

    assign Pending     = pend;
    assign WriteReg    = wreg_q;
    assign Data        = wdata_q;
    assign WriteEnable = we_q;
    assign Count       = count_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_writeback_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, mem_valid, hold;
    logic [3:0]    alu_reg, mem_reg;
    logic [31:0]   alu_data, mem_data;
    logic          alu_ready, mem_ready, write_enable;
    logic [3:0]    write_reg;
    logic [31:0]   data;
    logic [15:0]   pending;
    logic [CW-1:0] count;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .Reset(rst_n),
        .AluValid(alu_valid), .AluReg(alu_reg), .AluData(alu_data), .AluReady(alu_ready),
        .MemValid(mem_valid), .MemReg(mem_reg), .MemData(mem_data), .MemReady(mem_ready),
        .Hold(hold), .WriteReg(write_reg), .Data(data), .WriteEnable(write_enable),
        .Pending(pending), .Count(count)
    );

    always #5 clk = ~clk;

    // Reference model: list of pending {reg,data} writes plus the output registers.
    logic [35:0] exp_q[$];
    logic        m_we;
    logic [3:0]  m_reg;
    logic [31:0] m_data;
    int          n_checks = 0;
    int          n_bad    = 0;
    int          n_issued = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_pending();
        logic [15:0] p = 16'd0;
        foreach (exp_q[i]) p[exp_q[i][35:32]] = 1'b1;
        if (m_we) p[m_reg] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic check_outputs();
        check_eq("count",    32'(count),        32'(exp_q.size()));
        check_eq("we",       32'(write_enable), 32'(m_we));
        check_eq("wreg",     32'(write_reg),    32'(m_reg));
        check_eq("data",     data,              m_data);
        check_eq("pending",  32'(pending),      32'(model_pending()));
    endtask

    task automatic model_edge(input logic av, input logic [3:0] ar, input logic [31:0] ad,
                              input logic mv, input logic [3:0] mr, input logic [31:0] md,
                              input logic hd);
        bit          room      = (exp_q.size() < DEPTH);
        bit          was_empty = (exp_q.size() == 0);
        bit          take      = room && (av || mv);
        logic [3:0]  r         = av ? ar : mr;
        logic [31:0] d         = av ? ad : md;
        bit          bypass    = 1'b0;
        logic [35:0] head;
`ifdef WBQ_BYPASS_EN
        bypass = take && (r != 4'd0) && was_empty && !hd;
`endif
        if (!hd && !was_empty) begin
            head   = exp_q.pop_front();
            m_we   = 1'b1;
            m_reg  = head[35:32];
            m_data = head[31:0];
            n_issued++;
        end else if (bypass) begin
            m_we   = 1'b1;
            m_reg  = r;
            m_data = d;
            n_issued++;
        end else begin
            m_we   = 1'b0;
        end
        if (take && (r != 4'd0) && !bypass) exp_q.push_back({r, d});
    endtask

    // One cycle: drive at the falling edge, check readies, update model at the rising edge,
    // then check registered outputs at the next falling edge.
    task automatic step(input logic av, input logic [3:0] ar, input logic [31:0] ad,
                        input logic mv, input logic [3:0] mr, input logic [31:0] md,
                        input logic hd);
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        hold = hd;
        #1;
        check_eq("alu_ready", 32'(alu_ready), 32'(exp_q.size() != DEPTH));
        check_eq("mem_ready", 32'(mem_ready), 32'((exp_q.size() != DEPTH) && !av));
        @(posedge clk);
        model_edge(av, ar, ad, mv, mr, md, hd);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic hd);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, hd);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0; hold = 1'b0;
        #1;
        check_eq("rst_count",   32'(count),        32'd0);
        check_eq("rst_we",      32'(write_enable), 32'd0);
        check_eq("rst_wreg",    32'(write_reg),    32'd0);
        check_eq("rst_data",    data,              32'd0);
        check_eq("rst_pending", 32'(pending),      32'd0);
        exp_q.delete();
        m_we = 1'b0; m_reg = 4'd0; m_data = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int issued_before;
        rst_n = 1'b1;
        alu_valid = 1'b0; alu_reg = 4'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_reg = 4'd0; mem_data = 32'd0;
        hold = 1'b0;
        @(negedge clk);
        pulse_reset();

        // Single ALU write to r3
        step(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'd0, 1'b0);
`ifndef WBQ_BYPASS_EN
        check_eq("r3_pending_queued", 32'(pending[3]), 32'd1);
        check_eq("r3_we_early",       32'(write_enable), 32'd0);
`endif
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
        check_eq("r3_we",   32'(write_enable), 32'd1);
        check_eq("r3_wreg", 32'(write_reg),    32'd3);
        check_eq("r3_data", data,              32'h11);
        idle(2, 1'b0);

        // ALU beats load in the same cycle, load re-offered next cycle
        step(1'b1, 4'd2, 32'hA, 1'b1, 4'd5, 32'hB, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'hB, 1'b0);
        idle(3, 1'b0);

        // Fill under Hold, fifth offer refused, then drain in order
        for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 32'(100 + i), 1'b0, 4'd0, 32'd0, 1'b1);
        check_eq("full_count", 32'(count), 32'(DEPTH));
        alu_valid = 1'b1; #1;
        check_eq("full_alu_ready", 32'(alu_ready), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 4'd5, 32'd105, 1'b0, 4'd0, 32'd0, 1'b0);
        idle(6, 1'b0);

        // Register 0 offers vanish
        step(1'b1, 4'd0, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'd0, 1'b0);
        idle(2, 1'b0);
        check_eq("r0_pending", 32'(pending), 32'd0);

        // Reset with three entries queued drops them
        for (int i = 0; i < 3; i++) step(1'b1, 4'(9 + i), 32'(i), 1'b0, 4'd0, 32'd0, 1'b1);
        check_eq("pre_rst_count", 32'(count), 32'd3);
        pulse_reset();
        issued_before = n_issued;
        idle(4, 1'b0);
        check_eq("post_rst_issued", 32'(n_issued), 32'(issued_before));

`ifdef WBQ_BYPASS_EN
        step(1'b1, 4'd7, 32'h42, 1'b0, 4'd0, 32'd0, 1'b0);
        check_eq("byp_we",    32'(write_enable), 32'd1);
        check_eq("byp_wreg",  32'(write_reg),    32'd7);
        check_eq("byp_count", 32'(count),        32'd0);
        idle(2, 1'b0);
`endif

        // Random traffic, with an occasional mid-run reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 9) < 3));
        end
        idle(8, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
